// File: rtl/regfile_rw_if.sv
// rtl/regfile_rw_if.sv - write, read and dump-stream signals of the register file
interface regfile_rw_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              dump_req;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, dump_req, dump_ready,
    input  rdata1, rdata2, dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, dump_req, dump_ready,
    output rdata1, rdata2, dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/regfile_rw.sv
// rtl/regfile_rw.sv - 32x32 MIPS register file, bypassed read ports, sequential dump stream
module regfile_rw #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_rw_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic [ADDR_W-1:0] next_idx;
  logic              beat_xfer;
  logic              last_beat;

  // $0 reads as zero; a write in flight to the same index wins over the stored value
  function automatic logic [DATA_W-1:0] value_of(
    input logic [ADDR_W-1:0] a,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (a == '0)                  return '0;
    else if (we && waddr == a)    return wdata;
    else                          return stored;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (bus.we && bus.waddr != '0) regs_d[bus.waddr] = bus.wdata;
  end

  assign bus.rdata1 = value_of(bus.raddr1, bus.we, bus.waddr, bus.wdata, regs_q[bus.raddr1]);
  assign bus.rdata2 = value_of(bus.raddr2, bus.we, bus.waddr, bus.wdata, regs_q[bus.raddr2]);

  assign next_idx  = dump_idx_q + ADDR_W'(1);
  assign beat_xfer = (state_q == S_SEND) && bus.dump_ready;
  assign last_beat = (dump_idx_q == ADDR_W'(NREG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.dump_req) state_d = S_SEND;
      S_SEND:  if (beat_xfer && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat data is captured at load time, so a stalled beat ignores later writes
  always_comb begin
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    if (state_q == S_IDLE && bus.dump_req) begin
      dump_idx_d  = '0;
      dump_data_d = value_of('0, bus.we, bus.waddr, bus.wdata, regs_q[0]);
    end else if (beat_xfer && !last_beat) begin
      dump_idx_d  = next_idx;
      dump_data_d = value_of(next_idx, bus.we, bus.waddr, bus.wdata, regs_q[next_idx]);
    end
  end

  always_comb begin
    bus.dump_valid = (state_q == S_SEND);
    bus.dump_busy  = (state_q == S_SEND);
    bus.dump_done  = (state_q == S_DONE);
    bus.dump_idx   = dump_idx_q;
    bus.dump_data  = dump_data_q;
  end
endmodule

// File: tb/tb_regfile_rw.sv
// tb/tb_regfile_rw.sv - directed scoreboard bench for regfile_rw
module tb_regfile_rw;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t       sb_q[$];
  logic [31:0] model [32];
  int          cyc_used;

  regfile_rw_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_rw #(.ADDR_W(5), .DATA_W(32), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    step();
    bus.we = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic start_dump();
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = model[i];
      sb_q.push_back(b);
    end
    bus.dump_req = 1'b1;
    step();
    bus.dump_req = 1'b0;
  endtask

  // Pops and compares each transferred beat; stops early when the beat at stop_at is presented
  task automatic drain(input int stop_at);
    beat_t b;
    bit    stopped;
    int    cyc;
    stopped = 1'b0;
    cyc     = 0;
    while (sb_q.size() > 0 && cyc < 64 && !stopped) begin
      if (bus.dump_valid && stop_at >= 0 && int'(bus.dump_idx) == stop_at) begin
        stopped = 1'b1;
      end else begin
        if (bus.dump_valid && bus.dump_ready) begin
          b = sb_q.pop_front();
          chk("beat_idx", 32'(bus.dump_idx), 32'(b.idx));
          chk("beat_data", bus.dump_data, b.data);
        end
        step();
        cyc++;
      end
    end
    if (!stopped && sb_q.size() != 0) chk("drain_timeout_left", sb_q.size(), 0);
    cyc_used = cyc;
  endtask

  task automatic check_done_pulse();
    chk("done_pulse", 32'(bus.dump_done), 1);
    chk("done_valid_low", 32'(bus.dump_valid), 0);
    step();
    chk("done_one_cycle", 32'(bus.dump_done), 0);
    chk("idle_busy_low", 32'(bus.dump_busy), 0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.we         = 1'b0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.raddr1     = 5'd5;
    bus.raddr2     = 5'd31;
    bus.dump_req   = 1'b0;
    bus.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    step();
    step();
    chk("rst_valid", 32'(bus.dump_valid), 0);
    chk("rst_busy", 32'(bus.dump_busy), 0);
    chk("rst_done", 32'(bus.dump_done), 0);
    chk("rst_idx", 32'(bus.dump_idx), 0);
    chk("rst_data", bus.dump_data, 0);
    chk("rst_reg5", bus.rdata1, 0);
    chk("rst_reg31", bus.rdata2, 0);
    rst_n = 1'b1;
    step();

    // 1: plain write then read
    wr(5'd5, 32'hDEADBEEF);
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd0;
    #1;
    chk("t1_rd1", bus.rdata1, 32'hDEADBEEF);
    chk("t1_rd2_zero", bus.rdata2, 0);

    // 2: $0 writes are dropped, including on the bypass path
    bus.we     = 1'b1;
    bus.waddr  = 5'd0;
    bus.wdata  = 32'hFFFFFFFF;
    bus.raddr1 = 5'd0;
    #1;
    chk("t2_bypass_r0", bus.rdata1, 0);
    step();
    bus.we = 1'b0;
    #1;
    chk("t2_r0", bus.rdata1, 0);

    // 3: same-cycle bypass on both ports
    wr(5'd31, 32'h1);
    bus.we     = 1'b1;
    bus.waddr  = 5'd31;
    bus.wdata  = 32'h00400008;
    bus.raddr1 = 5'd31;
    bus.raddr2 = 5'd31;
    #1;
    chk("t3_byp1", bus.rdata1, 32'h00400008);
    chk("t3_byp2", bus.rdata2, 32'h00400008);
    step();
    bus.we = 1'b0;
    model[31] = 32'h00400008;
    #1;
    chk("t3_stored", bus.rdata1, 32'h00400008);

    // 4: full dump with ready held high
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 32'h11));
    bus.dump_ready = 1'b1;
    start_dump();
    chk("t4_first_valid", 32'(bus.dump_valid), 1);
    chk("t4_busy", 32'(bus.dump_busy), 1);
    drain(-1);
    chk("t4_cycles", 32'(cyc_used), 32);
    check_done_pulse();

    // 5: stall at idx 7 while reg 7 is rewritten
    start_dump();
    drain(7);
    bus.dump_ready = 1'b0;
    wr(5'd7, 32'hAAAA5555);
    step();
    chk("t5_hold_idx", 32'(bus.dump_idx), 7);
    chk("t5_hold_data", bus.dump_data, sb_q[0].data);
    chk("t5_hold_valid", 32'(bus.dump_valid), 1);
    bus.dump_ready = 1'b1;
    drain(-1);
    check_done_pulse();
    bus.raddr1 = 5'd7;
    #1;
    chk("t5_reg7", bus.rdata1, 32'hAAAA5555);

    // 6: reset mid-dump
    start_dump();
    drain(12);
    chk("t6_at12", 32'(bus.dump_idx), 12);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    for (int i = 0; i < 32; i++) model[i] = '0;
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd31;
    #1;
    chk("t6_valid", 32'(bus.dump_valid), 0);
    chk("t6_busy", 32'(bus.dump_busy), 0);
    chk("t6_reg5", bus.rdata1, 0);
    chk("t6_reg31", bus.rdata2, 0);
    step();
    chk("t6_no_done_rst", 32'(bus.dump_done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_done", 32'(bus.dump_done), 0);
    end
    start_dump();
    chk("t6_restart_idx", 32'(bus.dump_idx), 0);
    drain(-1);
    check_done_pulse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
